ex_hazard_controller: RTL and testbench

- Schedules the execute stage. Decides, for each instruction leaving decode, where the ALU top and bottom operands come from: ID/EX data, EX/MEM forward, or MEM/WB forward.
- Detects load-use hazards and sequences multi-cycle ALU operations. While either is pending, it stalls the front end and injects bubbles into ID/EX.
- Sits between decode and the ID/EX register. Its registered select outputs drive the alu_top_sel/alu_bot_sel fields of ID/EX.

---
 rtl/ex_hazard_controller.sv | 152 +++++++++++++++
 tb/tb_ex_hazard_controller.sv | 576 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_controller.sv
// ex_hazard_controller: execute-stage scheduler.
// - Selects where each ALU operand comes from: ID/EX data, EX/MEM forward or MEM/WB forward.
// - Stalls the front end and injects a bubble on a load-use hazard.
// - Holds ID/EX while a multi-cycle ALU operation occupies EX.
// Optional feature: define HAZ_PERF_CNT_EN to add saturating stall-cause counters.
module ex_hazard_controller #(
  parameter int REG_W    = 5,
  parameter int MC_CNT_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_src_top,
  input  logic [REG_W-1:0]    id_src_bot,
  input  logic                id_use_top,
  input  logic                id_use_bot,
  input  logic [MC_CNT_W-1:0] id_mc_len,
  input  logic [REG_W-1:0]    ex_dst,
  input  logic                ex_wr,
  input  logic                ex_is_load,
  input  logic [REG_W-1:0]    exm_dst,
  input  logic                exm_wr,
  input  logic                exm_half,
  input  logic [REG_W-1:0]    mwb_dst,
  input  logic                mwb_wr,
  input  logic                mwb_half,
  output logic [4:0]          alu_top_sel,
  output logic [4:0]          alu_bot_sel,
  output logic                stall,
  output logic                bubble,
  output logic                ex_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]         load_stall_cnt,
  output logic [15:0]         mc_stall_cnt
`endif
);

  localparam logic [4:0] SEL_IDEX  = 5'b00001;
  localparam logic [4:0] SEL_EXM_T = 5'b00010;
  localparam logic [4:0] SEL_EXM_B = 5'b00100;
  localparam logic [4:0] SEL_MWB_T = 5'b01000;
  localparam logic [4:0] SEL_MWB_B = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MC_BUSY    = 2'd2
  } state_t;

  state_t              r_state;
  logic [MC_CNT_W-1:0] r_mc_cnt;
  logic [4:0]          r_top_sel;
  logic [4:0]          r_bot_sel;

  // Operand 0 is the top operand, operand 1 the bottom operand.
  logic [1:0]            w_use;
  logic [1:0][REG_W-1:0] w_src;
  logic [1:0][4:0]       w_sel;
  logic [1:0]            w_ld_hit;
  logic                  w_load_hazard;
  logic                  w_mc_start;

  assign w_use = {id_use_bot, id_use_top};
  assign w_src = {id_src_bot, id_src_top};

  // Per-operand forwarding select; register 0 is hard-wired, so it never forwards.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      logic w_src_nz;
      logic w_exm_hit;
      logic w_mwb_hit;
      assign w_src_nz     = (w_src[gi] != '0);
      assign w_exm_hit    = w_use[gi] & w_src_nz & exm_wr & (w_src[gi] == exm_dst);
      assign w_mwb_hit    = w_use[gi] & w_src_nz & mwb_wr & (w_src[gi] == mwb_dst);
      assign w_ld_hit[gi] = w_use[gi] & (w_src[gi] == ex_dst);
      assign w_sel[gi]    = w_exm_hit ? (exm_half ? SEL_EXM_B : SEL_EXM_T) :
                            w_mwb_hit ? (mwb_half ? SEL_MWB_B : SEL_MWB_T) :
                                        SEL_IDEX;
    end
  endgenerate

  assign w_load_hazard = (r_state == S_IDLE) & id_valid & ex_is_load & ex_wr & (|w_ld_hit);
  assign w_mc_start    = id_valid & (id_mc_len != '0);

  // Front-end control is combinational so the hold takes effect in the same cycle.
  assign stall       = ~reset & ((r_state != S_IDLE) | w_load_hazard);
  assign bubble      = ~reset & w_load_hazard;
  assign ex_busy     = (r_state == S_MC_BUSY);
  assign alu_top_sel = r_top_sel;
  assign alu_bot_sel = r_bot_sel;

  // Scheduler FSM: selects update only when the decode instruction advances into ID/EX.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mc_cnt  <= '0;
      r_top_sel <= SEL_IDEX;
      r_bot_sel <= SEL_IDEX;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load_hazard) begin
            // The bubble entering ID/EX reads nothing, so it carries the neutral select.
            r_top_sel <= SEL_IDEX;
            r_bot_sel <= SEL_IDEX;
            r_state   <= S_LOAD_STALL;
          end else begin
            r_top_sel <= id_valid ? w_sel[0] : SEL_IDEX;
            r_bot_sel <= id_valid ? w_sel[1] : SEL_IDEX;
            if (w_mc_start) begin
              r_mc_cnt <= id_mc_len;
              r_state  <= S_MC_BUSY;
            end
          end
        end
        S_LOAD_STALL: begin
          r_state <= S_IDLE;
        end
        S_MC_BUSY: begin
          r_mc_cnt <= r_mc_cnt - 1'b1;
          if (r_mc_cnt <= 1) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_mc_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating stall counters; any stall outside MC_BUSY is caused by a load-use hazard.
  always_ff @(posedge clock) begin
    if (reset) begin
      load_stall_cnt <= '0;
      mc_stall_cnt   <= '0;
    end else begin
      if (stall && (r_state != S_MC_BUSY) && (load_stall_cnt != 16'hFFFF)) begin
        load_stall_cnt <= load_stall_cnt + 16'd1;
      end
      if (stall && (r_state == S_MC_BUSY) && (mc_stall_cnt != 16'hFFFF)) begin
        mc_stall_cnt <= mc_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Testbench for ex_hazard_controller: scoreboard of expected select pairs,
// pushed when an advancing instruction is driven and popped one cycle later.
module tb_ex_hazard_controller;

  localparam int REG_W    = 5;
  localparam int MC_CNT_W = 4;

  logic                clock;
  logic                reset;
  logic                id_valid;
  logic [REG_W-1:0]    id_src_top;
  logic [REG_W-1:0]    id_src_bot;
  logic                id_use_top;
  logic                id_use_bot;
  logic [MC_CNT_W-1:0] id_mc_len;
  logic [REG_W-1:0]    ex_dst;
  logic                ex_wr;
  logic                ex_is_load;
  logic [REG_W-1:0]    exm_dst;
  logic                exm_wr;
  logic                exm_half;
  logic [REG_W-1:0]    mwb_dst;
  logic                mwb_wr;
  logic                mwb_half;
  logic [4:0]          alu_top_sel;
  logic [4:0]          alu_bot_sel;
  logic                stall;
  logic                bubble;
  logic                ex_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0]         load_stall_cnt;
  logic [15:0]         mc_stall_cnt;
`endif

  typedef struct packed {
    logic [4:0] top;
    logic [4:0] bot;
  } sel_t;

  sel_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  ex_hazard_controller #(.REG_W(REG_W), .MC_CNT_W(MC_CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_src_top (id_src_top),
    .id_src_bot (id_src_bot),
    .id_use_top (id_use_top),
    .id_use_bot (id_use_bot),
    .id_mc_len  (id_mc_len),
    .ex_dst     (ex_dst),
    .ex_wr      (ex_wr),
    .ex_is_load (ex_is_load),
    .exm_dst    (exm_dst),
    .exm_wr     (exm_wr),
    .exm_half   (exm_half),
    .mwb_dst    (mwb_dst),
    .mwb_wr     (mwb_wr),
    .mwb_half   (mwb_half),
    .alu_top_sel(alu_top_sel),
    .alu_bot_sel(alu_bot_sel),
    .stall      (stall),
    .bubble     (bubble),
    .ex_busy    (ex_busy)
`ifdef HAZ_PERF_CNT_EN
    ,
    .load_stall_cnt(load_stall_cnt),
    .mc_stall_cnt  (mc_stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid   = 1'b0;
    id_src_top = '0;
    id_src_bot = '0;
    id_use_top = 1'b0;
    id_use_bot = 1'b0;
    id_mc_len  = '0;
    ex_dst     = '0;
    ex_wr      = 1'b0;
    ex_is_load = 1'b0;
    exm_dst    = '0;
    exm_wr     = 1'b0;
    exm_half   = 1'b0;
    mwb_dst    = '0;
    mwb_wr     = 1'b0;
    mwb_half   = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    id_valid   = 1'b1;
    id_src_top = REG_W'($urandom_range(0, 31));
    id_src_bot = REG_W'($urandom_range(0, 31));
    id_use_top = 1'b1;
    id_use_bot = 1'b1;
    id_mc_len  = MC_CNT_W'($urandom_range(0, 15));
    ex_dst     = id_src_top;
    ex_wr      = 1'b1;
    ex_is_load = 1'b1;
    exm_dst    = id_src_bot;
    exm_wr     = 1'b1;
    exm_half   = 1'b1;
    mwb_dst    = id_src_top;
    mwb_wr     = 1'b1;
    mwb_half   = 1'b1;
    tick();
    vectors++;
    if ({stall, bubble} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ctl_in_reset: stall,bubble got %b expected 00", {stall, bubble});
    end
    tick();
    vectors++;
    if ({alu_top_sel, alu_bot_sel, stall, bubble, ex_busy} !== {5'b00001, 5'b00001, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_state: top=%b bot=%b stall=%b bubble=%b busy=%b expected 00001 00001 0 0 0",
               alu_top_sel, alu_bot_sel, stall, bubble, ex_busy);
    end
`ifdef HAZ_PERF_CNT_EN
    vectors++;
    if ({load_stall_cnt, mc_stall_cnt} !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_perf: load=%0d mc=%0d expected 0 0", load_stall_cnt, mc_stall_cnt);
    end
`endif
    $display("reset: top=%b bot=%b busy=%b", alu_top_sel, alu_bot_sel, ex_busy);
    clear_inputs();
    reset = 1'b0;
  endtask

  // Four back-to-back advancing instructions covering every forward source for the top operand.
  task automatic test_fwd_top();
    logic [4:0] exp_tab [4];
    sel_t e;
    exp_tab[0] = 5'b00010;
    exp_tab[1] = 5'b00100;
    exp_tab[2] = 5'b01000;
    exp_tab[3] = 5'b10000;
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      id_valid   = 1'b1;
      id_use_top = 1'b1;
      id_src_top = 5'd3;
      exm_dst    = 5'd3;
      exm_wr     = (k < 2);
      exm_half   = (k % 2 == 1);
      mwb_dst    = 5'd3;
      mwb_wr     = (k >= 2);
      mwb_half   = (k % 2 == 1);
      exp_q.push_back({exp_tab[k], 5'b00001});
      #2;
      vectors++;
      if (stall !== 1'b0) begin
        miscompares++;
        $display("FAIL fwd_top_stall[%0d]: got %b expected 0", k, stall);
      end
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({alu_top_sel, alu_bot_sel} !== e) begin
        miscompares++;
        $display("FAIL fwd_top[%0d]: got %b/%b expected %b/%b", k, alu_top_sel, alu_bot_sel, e.top, e.bot);
      end
      $display("fwd_top[%0d]: top=%b bot=%b", k, alu_top_sel, alu_bot_sel);
    end
  endtask

  // Register 0 never forwards and an unused operand keeps the ID/EX select.
  task automatic test_r0_unused();
    sel_t e;
    clear_inputs();
    id_valid   = 1'b1;
    id_use_top = 1'b1;
    id_src_top = 5'd0;
    exm_dst    = 5'd0;
    exm_wr     = 1'b1;
    exp_q.push_back({5'b00001, 5'b00001});
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({alu_top_sel, alu_bot_sel} !== e) begin
      miscompares++;
      $display("FAIL r0_no_fwd: got %b/%b expected %b/%b", alu_top_sel, alu_bot_sel, e.top, e.bot);
    end
    $display("r0_no_fwd: top=%b bot=%b", alu_top_sel, alu_bot_sel);
    clear_inputs();
    id_valid   = 1'b1;
    id_use_top = 1'b0;
    id_src_top = 5'd4;
    id_use_bot = 1'b1;
    id_src_bot = 5'd4;
    exm_dst    = 5'd4;
    exm_wr     = 1'b1;
    exp_q.push_back({5'b00001, 5'b00010});
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({alu_top_sel, alu_bot_sel} !== e) begin
      miscompares++;
      $display("FAIL unused_top: got %b/%b expected %b/%b", alu_top_sel, alu_bot_sel, e.top, e.bot);
    end
    $display("unused_top: top=%b bot=%b", alu_top_sel, alu_bot_sel);
  endtask

  task automatic test_priority();
    sel_t e;
    clear_inputs();
    id_valid   = 1'b1;
    id_use_top = 1'b1;
    id_src_top = 5'd6;
    id_use_bot = 1'b1;
    id_src_bot = 5'd5;
    exm_dst    = 5'd5;
    exm_wr     = 1'b1;
    exm_half   = 1'b1;
    mwb_dst    = 5'd5;
    mwb_wr     = 1'b1;
    mwb_half   = 1'b0;
    exp_q.push_back({5'b00001, 5'b00100});
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({alu_top_sel, alu_bot_sel} !== e) begin
      miscompares++;
      $display("FAIL priority: got %b/%b expected %b/%b", alu_top_sel, alu_bot_sel, e.top, e.bot);
    end
    $display("priority: top=%b bot=%b", alu_top_sel, alu_bot_sel);
  endtask

  // No valid instruction: no stall even with hazard-looking inputs, selects fall to ID/EX.
  task automatic test_invalid();
    sel_t e;
    clear_inputs();
    id_valid   = 1'b0;
    id_use_top = 1'b1;
    id_src_top = 5'd5;
    id_use_bot = 1'b1;
    id_src_bot = 5'd5;
    exm_dst    = 5'd5;
    exm_wr     = 1'b1;
    ex_dst     = 5'd5;
    ex_wr      = 1'b1;
    ex_is_load = 1'b1;
    exp_q.push_back({5'b00001, 5'b00001});
    #2;
    vectors++;
    if ({stall, bubble} !== 2'b00) begin
      miscompares++;
      $display("FAIL invalid_ctl: stall,bubble got %b expected 00", {stall, bubble});
    end
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({alu_top_sel, alu_bot_sel} !== e) begin
      miscompares++;
      $display("FAIL invalid_sel: got %b/%b expected %b/%b", alu_top_sel, alu_bot_sel, e.top, e.bot);
    end
    $display("invalid: top=%b bot=%b stall=%b", alu_top_sel, alu_bot_sel, stall);
  endtask

  task automatic test_load_use();
    sel_t e;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] ld0;
`endif
    // An advancing forward first, so the bubble's neutral select is observable.
    clear_inputs();
    id_valid   = 1'b1;
    id_use_top = 1'b1;
    id_src_top = 5'd3;
    exm_dst    = 5'd3;
    exm_wr     = 1'b1;
    exp_q.push_back({5'b00010, 5'b00001});
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({alu_top_sel, alu_bot_sel} !== e) begin
      miscompares++;
      $display("FAIL load_pre: got %b/%b expected %b/%b", alu_top_sel, alu_bot_sel, e.top, e.bot);
    end
`ifdef HAZ_PERF_CNT_EN
    ld0 = load_stall_cnt;
`endif
    // Cycle 0: hazard detected.
    clear_inputs();
    id_valid   = 1'b1;
    id_use_bot = 1'b1;
    id_src_bot = 5'd7;
    ex_dst     = 5'd7;
    ex_wr      = 1'b1;
    ex_is_load = 1'b1;
    exp_q.push_back({5'b00001, 5'b00001});
    #2;
    vectors++;
    if ({stall, bubble} !== 2'b11) begin
      miscompares++;
      $display("FAIL load_c0: stall,bubble got %b expected 11", {stall, bubble});
    end
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({alu_top_sel, alu_bot_sel} !== e) begin
      miscompares++;
      $display("FAIL load_bubble_sel: got %b/%b expected %b/%b", alu_top_sel, alu_bot_sel, e.top, e.bot);
    end
    $display("load_c0: top=%b bot=%b", alu_top_sel, alu_bot_sel);
    // Cycle 1: the load has moved to EX/MEM, bubble sits in EX.
    ex_is_load = 1'b0;
    ex_wr      = 1'b0;
    exm_dst    = 5'd7;
    exm_wr     = 1'b1;
    exm_half   = 1'b1;
    #2;
    vectors++;
    if ({stall, bubble, ex_busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL load_c1: stall,bubble,busy got %b expected 100", {stall, bubble, ex_busy});
    end
    tick();
    vectors++;
    if ({alu_top_sel, alu_bot_sel} !== {5'b00001, 5'b00001}) begin
      miscompares++;
      $display("FAIL load_c1_hold: got %b/%b expected 00001/00001", alu_top_sel, alu_bot_sel);
    end
    $display("load_c1: stall_cycle done");
    // Cycle 2: re-evaluated, load now in MEM/WB.
    exm_wr   = 1'b0;
    mwb_dst  = 5'd7;
    mwb_wr   = 1'b1;
    mwb_half = 1'b0;
    exp_q.push_back({5'b00001, 5'b01000});
    #2;
    vectors++;
    if ({stall, bubble} !== 2'b00) begin
      miscompares++;
      $display("FAIL load_c2: stall,bubble got %b expected 00", {stall, bubble});
    end
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({alu_top_sel, alu_bot_sel} !== e) begin
      miscompares++;
      $display("FAIL load_c2_sel: got %b/%b expected %b/%b", alu_top_sel, alu_bot_sel, e.top, e.bot);
    end
    $display("load_c2: top=%b bot=%b", alu_top_sel, alu_bot_sel);
`ifdef HAZ_PERF_CNT_EN
    vectors++;
    if (load_stall_cnt - ld0 !== 16'd2) begin
      miscompares++;
      $display("FAIL load_perf: got %0d expected 2", load_stall_cnt - ld0);
    end
`endif
  endtask

  // Hazard and multi-cycle together: hazard first, multi-cycle on re-evaluation.
  task automatic test_hazard_and_mc();
    sel_t e;
    clear_inputs();
    id_valid   = 1'b1;
    id_use_top = 1'b1;
    id_src_top = 5'd9;
    id_mc_len  = 4'd2;
    ex_dst     = 5'd9;
    ex_wr      = 1'b1;
    ex_is_load = 1'b1;
    #2;
    vectors++;
    if ({stall, bubble, ex_busy} !== 3'b110) begin
      miscompares++;
      $display("FAIL hzmc_c0: stall,bubble,busy got %b expected 110", {stall, bubble, ex_busy});
    end
    tick();
    ex_is_load = 1'b0;
    ex_wr      = 1'b0;
    #2;
    vectors++;
    if ({stall, bubble, ex_busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL hzmc_c1: stall,bubble,busy got %b expected 100", {stall, bubble, ex_busy});
    end
    tick();
    exp_q.push_back({5'b00001, 5'b00001});
    #2;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL hzmc_adv: stall got %b expected 0", stall);
    end
    tick();
    e = exp_q.pop_front();
    clear_inputs();
    vectors++;
    if ({alu_top_sel, alu_bot_sel} !== e) begin
      miscompares++;
      $display("FAIL hzmc_sel: got %b/%b expected %b/%b", alu_top_sel, alu_bot_sel, e.top, e.bot);
    end
    for (int b = 0; b < 2; b++) begin
      #2;
      vectors++;
      if ({ex_busy, stall} !== 2'b11) begin
        miscompares++;
        $display("FAIL hzmc_busy[%0d]: busy,stall got %b expected 11", b, {ex_busy, stall});
      end
      tick();
    end
    #2;
    vectors++;
    if ({ex_busy, stall} !== 2'b00) begin
      miscompares++;
      $display("FAIL hzmc_done: busy,stall got %b expected 00", {ex_busy, stall});
    end
    $display("hazard_mc: busy=%b stall=%b", ex_busy, stall);
  endtask

  task automatic test_multicycle();
    sel_t e;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] mc0;
    mc0 = mc_stall_cnt;
`endif
    tick();
    clear_inputs();
    id_valid   = 1'b1;
    id_use_top = 1'b1;
    id_src_top = 5'd3;
    id_mc_len  = 4'd3;
    exm_dst    = 5'd3;
    exm_wr     = 1'b1;
    exp_q.push_back({5'b00010, 5'b00001});
    #2;
    vectors++;
    if ({stall, ex_busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL mc_adv: stall,busy got %b expected 00", {stall, ex_busy});
    end
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({alu_top_sel, alu_bot_sel} !== e) begin
      miscompares++;
      $display("FAIL mc_sel: got %b/%b expected %b/%b", alu_top_sel, alu_bot_sel, e.top, e.bot);
    end
    // Next instruction waits in decode with a different forward.
    id_mc_len = 4'd0;
    exm_half  = 1'b1;
    for (int b = 0; b < 3; b++) begin
      #2;
      vectors++;
      if ({ex_busy, stall, bubble} !== 3'b110) begin
        miscompares++;
        $display("FAIL mc_busy[%0d]: busy,stall,bubble got %b expected 110", b, {ex_busy, stall, bubble});
      end
      tick();
      vectors++;
      if ({alu_top_sel, alu_bot_sel} !== e) begin
        miscompares++;
        $display("FAIL mc_hold[%0d]: got %b/%b expected %b/%b", b, alu_top_sel, alu_bot_sel, e.top, e.bot);
      end
      $display("mc_busy[%0d]: top=%b", b, alu_top_sel);
    end
    exp_q.push_back({5'b00100, 5'b00001});
    #2;
    vectors++;
    if ({ex_busy, stall} !== 2'b00) begin
      miscompares++;
      $display("FAIL mc_done: busy,stall got %b expected 00", {ex_busy, stall});
    end
    tick();
    e = exp_q.pop_front();
    vectors++;
    if ({alu_top_sel, alu_bot_sel} !== e) begin
      miscompares++;
      $display("FAIL mc_next: got %b/%b expected %b/%b", alu_top_sel, alu_bot_sel, e.top, e.bot);
    end
    $display("mc_next: top=%b bot=%b", alu_top_sel, alu_bot_sel);
`ifdef HAZ_PERF_CNT_EN
    vectors++;
    if (mc_stall_cnt - mc0 !== 16'd3) begin
      miscompares++;
      $display("FAIL mc_perf: got %0d expected 3", mc_stall_cnt - mc0);
    end
`endif
  endtask

  task automatic test_reset_mid_mc();
    sel_t e;
    clear_inputs();
    id_valid   = 1'b1;
    id_use_bot = 1'b1;
    id_src_bot = 5'd12;
    id_mc_len  = 4'd5;
    exm_dst    = 5'd12;
    exm_wr     = 1'b1;
    exm_half   = 1'b1;
    exp_q.push_back({5'b00001, 5'b00100});
    tick();
    e = exp_q.pop_front();
    clear_inputs();
    vectors++;
    if ({alu_top_sel, alu_bot_sel} !== e) begin
      miscompares++;
      $display("FAIL rmc_sel: got %b/%b expected %b/%b", alu_top_sel, alu_bot_sel, e.top, e.bot);
    end
    #2;
    vectors++;
    if ({ex_busy, stall} !== 2'b11) begin
      miscompares++;
      $display("FAIL rmc_busy1: busy,stall got %b expected 11", {ex_busy, stall});
    end
    tick();
    reset = 1'b1;
    #2;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rmc_stall_in_reset: got %b expected 0", stall);
    end
    tick();
    vectors++;
    if ({ex_busy, stall, alu_top_sel, alu_bot_sel} !== {2'b00, 5'b00001, 5'b00001}) begin
      miscompares++;
      $display("FAIL rmc_after: busy=%b stall=%b top=%b bot=%b expected 0 0 00001 00001",
               ex_busy, stall, alu_top_sel, alu_bot_sel);
    end
`ifdef HAZ_PERF_CNT_EN
    vectors++;
    if ({load_stall_cnt, mc_stall_cnt} !== 32'd0) begin
      miscompares++;
      $display("FAIL rmc_perf: load=%0d mc=%0d expected 0 0", load_stall_cnt, mc_stall_cnt);
    end
`endif
    $display("reset_mid_mc: busy=%b stall=%b", ex_busy, stall);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_fwd_top();
    test_r0_unused();
    test_priority();
    test_invalid();
    test_load_use();
    test_hazard_and_mc();
    test_multicycle();
    test_reset_mid_mc();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
